// File: rtl/if_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave).
// Handshake: req is held with addr stable until ack; ack may arrive in the same cycle as req,
// one ack completes one request, and ack while req=0 carries no meaning.
interface if_fetch_stage_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over the imem bus, feeds IF/ID registers,
// buffers one instruction returned during a stall, and flushes on redirect.
module if_fetch_stage #(
  parameter int                 PC_W      = 8,
  parameter int                 INSTR_W   = 8,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic                clk,
  input  logic                rst,
  if_fetch_stage_if.master    imem,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_W-1:0]     redirect_pc,
  output logic [INSTR_W-1:0]  instr_out,
  output logic [PC_W-1:0]     pc_out,
  output logic                instr_valid,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {FETCH = 2'd0, DRAIN = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [PC_W-1:0] PC_ONE = 1;

  state_t             state, state_nxt;
  logic [PC_W-1:0]    pc, pc_nxt;
  logic [PC_W-1:0]    target, target_nxt;
  logic [PC_W-1:0]    hold_pc, hold_pc_nxt;
  logic [INSTR_W-1:0] hold_instr, hold_instr_nxt;
  logic [INSTR_W-1:0] instr_nxt;
  logic [PC_W-1:0]    pc_out_nxt;
  logic               valid_nxt;
  logic               acc;
  logic               load;
  logic [PC_W-1:0]    load_pc;
  logic [INSTR_W-1:0] load_instr;

  assign imem.imem_req  = !rst && (state != HOLD);
  assign imem.imem_addr = pc;
  assign acc            = imem.imem_req && imem.imem_ack;
  assign dbg_state      = state;

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    target_nxt     = target;
    hold_pc_nxt    = hold_pc;
    hold_instr_nxt = hold_instr;
    load           = 1'b0;
    load_pc        = pc;
    load_instr     = imem.imem_rdata;
    case (state)
      FETCH: begin
        if (acc) begin
          if (redirect_valid) begin
            pc_nxt = redirect_pc;
          end else if (!stall || !instr_valid) begin
            load   = 1'b1;
            pc_nxt = pc + PC_ONE;
          end else begin
            hold_pc_nxt    = pc;
            hold_instr_nxt = imem.imem_rdata;
            pc_nxt         = pc + PC_ONE;
            state_nxt      = HOLD;
          end
        end else if (redirect_valid) begin
          target_nxt = redirect_pc;
          state_nxt  = DRAIN;
        end
      end
      DRAIN: begin
        // The wrong-path request must still complete; the newest redirect target wins.
        if (redirect_valid) target_nxt = redirect_pc;
        if (acc) begin
          pc_nxt    = redirect_valid ? redirect_pc : target;
          state_nxt = FETCH;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_pc;
          state_nxt = FETCH;
        end else if (!stall) begin
          load       = 1'b1;
          load_pc    = hold_pc;
          load_instr = hold_instr;
          state_nxt  = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase

    instr_nxt  = instr_out;
    pc_out_nxt = pc_out;
    valid_nxt  = instr_valid;
    if (redirect_valid) begin
      valid_nxt = 1'b0;
      instr_nxt = NOP_INSTR;
    end else if (load) begin
      valid_nxt  = 1'b1;
      instr_nxt  = load_instr;
      pc_out_nxt = load_pc;
    end else if (!stall) begin
      valid_nxt = 1'b0;
      instr_nxt = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      target      <= '0;
      hold_pc     <= '0;
      hold_instr  <= '0;
      instr_out   <= NOP_INSTR;
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      target      <= target_nxt;
      hold_pc     <= hold_pc_nxt;
      hold_instr  <= hold_instr_nxt;
      instr_out   <= instr_nxt;
      pc_out      <= pc_out_nxt;
      instr_valid <= valid_nxt;
    end
  end

endmodule
